// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive path, also used by the TX side:
// receiver state encoding, FIFO geometry, data width and the bit-period helper
// that turns the baudrate register encoding into a period in clk cycles.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AW    = 4;
    localparam int unsigned CNT_W      = 17;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Bit period T = baudrate + 2, widened to 17 bits so the sum never wraps.
    function automatic logic [CNT_W-1:0] bit_period(input logic [15:0] baud);
        return {1'b0, baud} + 17'd2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 16 x 8 synchronous FIFO with a registered head.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write strobe and byte (ignored when full)
//   pop          : remove head (ignored when empty)
//   rdata        : registered head byte, valid while empty = 0
//   empty        : registered empty flag
//   full         : FIFO holds FIFO_DEPTH entries
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               empty_r;

    logic               do_push_s;
    logic               do_pop_s;
    logic [FIFO_AW-1:0] rd_ptr_n_s;
    logic [FIFO_AW:0]   count_n_s;
    logic [DATA_W-1:0]  head_n_s;

    assign full      = (count_r == FULL_COUNT);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty_r;

    // Next read pointer, occupancy and head byte.
    always_comb begin
        rd_ptr_n_s = rd_ptr_r;
        count_n_s  = count_r;
        head_n_s   = mem_r[rd_ptr_r];
        if (do_pop_s) begin
            rd_ptr_n_s = rd_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_n_s = count_r + {{FIFO_AW{1'b0}}, 1'b1};
            2'b01:   count_n_s = count_r - {{FIFO_AW{1'b0}}, 1'b1};
            default: count_n_s = count_r;
        endcase
        // When the slot being written becomes the head, forward the write data
        // because the memory only holds it after this edge.
        if (do_push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_n_s = wdata;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered head/empty outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
            rdata_r  <= {DATA_W{1'b0}};
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(FIFO_AW-1){1'b0}}, 1'b1};
            end
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
            rdata_r  <= head_n_s;
            empty_r  <= (count_n_s == {(FIFO_AW+1){1'b0}});
        end
    end

    assign rdata = rdata_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, feeding a 16-deep receive FIFO.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   baudrate[15:0]: bit period encoding, T = baudrate + 2 clk (baudrate >= 2)
//   rx            : asynchronous serial input, idles high
//   rx_pop        : one-cycle pop of the FIFO head
//   rx_data[7:0]  : FIFO head byte, valid while rx_empty = 0
//   rx_empty      : FIFO empty
//   rx_overrun    : 1-cycle pulse, good byte dropped because the FIFO was full
//   rx_frame_err  : 1-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       baudrate,
    input  logic              rx,
    input  logic              rx_pop,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_empty,
    output logic              rx_overrun,
    output logic              rx_frame_err
);

    logic [1:0]        sync_r;
    logic              rx_s;

    rx_state_t         state_r;
    logic [DATA_W-1:0] shift_r;
    logic [2:0]        bit_idx_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              overrun_r;
    logic              frame_err_r;

    logic [CNT_W-1:0]  period_s;
    logic [CNT_W-1:0]  period_m1_s;
    logic [CNT_W-1:0]  half_m1_s;
    logic              expired_s;
    logic              full_s;
    logic              push_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    assign rx_s        = sync_r[1];
    assign period_s    = bit_period(baudrate);
    assign period_m1_s = period_s - 17'd1;
    assign half_m1_s   = (period_s >> 1) - 17'd1;
    assign expired_s   = (wait_cnt_r == 17'd0);

    // A good stop bit only reaches the FIFO when there is room for it.
    assign push_s = (state_r == ST_STOP) & expired_s & rx_s & ~full_s;

    // Receive FSM: start verify, mid-bit data sampling, stop check, break hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= {DATA_W{1'b0}};
            bit_idx_r   <= 3'd0;
            wait_cnt_r  <= {CNT_W{1'b0}};
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            // Saturating down-count; state branches below override on reload.
            if (!expired_s) begin
                wait_cnt_r <= wait_cnt_r - 17'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        wait_cnt_r <= half_m1_s;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (expired_s) begin
                        if (!rx_s) begin
                            wait_cnt_r <= period_m1_s;
                            bit_idx_r  <= 3'd0;
                            state_r    <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (expired_s) begin
                        shift_r[bit_idx_r] <= rx_s;
                        wait_cnt_r         <= period_m1_s;
                        bit_idx_r          <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (expired_s) begin
                        if (rx_s) begin
                            overrun_r <= full_s;
                            state_r   <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line returns high so a long low is
                    // not mistaken for a fresh start bit.
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .wdata   (shift_r),
        .pop     (rx_pop),
        .rdata   (rx_data),
        .empty   (rx_empty),
        .full    (full_s)
    );

    assign rx_overrun   = overrun_r;
    assign rx_frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are bit-banged on rx; a byte model
// of the 16-entry FIFO (sb_q) records what should be received, and flag pulse
// counters are compared against expected counts.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk;
    logic        reset_n;
    logic [15:0] baudrate;
    logic        rx;
    logic        rx_pop;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_overrun;
    logic        rx_frame_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    int exp_ovr  = 0;
    int exp_ferr = 0;

    logic [7:0] sb_q[$];

    uart_rx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baudrate     (baudrate),
        .rx           (rx),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle each flag is high; a stuck flag inflates the count.
    always @(negedge clk) begin
        if (rx_overrun)   ovr_cnt  = ovr_cnt + 1;
        if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; the model predicts push / overrun / frame error.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        int t;
        t = int'(baudrate) + 2;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (t) @(negedge clk);
        end
        if (!stop) begin
            exp_ferr = exp_ferr + 1;
        end else if (sb_q.size() < 16) begin
            sb_q.push_back(d);
        end else begin
            exp_ovr = exp_ovr + 1;
        end
    endtask

    // Pop everything the model expects, then confirm empty and that a pop
    // while empty is ignored.
    task automatic drain(input string tag);
        logic [7:0] e;
        int n;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n = 0;
            while (rx_empty && n < 200) begin
                @(negedge clk);
                n = n + 1;
            end
            if (rx_empty) begin
                check_eq({tag, "_wait_data"}, 32'(rx_empty), 32'd0);
            end else begin
                check_eq({tag, "_data"}, 32'(rx_data), 32'(e));
                rx_pop = 1'b1;
                @(negedge clk);
                rx_pop = 1'b0;
            end
        end
        @(negedge clk);
        check_eq({tag, "_empty"}, 32'(rx_empty), 32'd1);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        @(negedge clk);
        check_eq({tag, "_empty_pop"}, 32'(rx_empty), 32'd1);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_overrun"}, 32'(ovr_cnt), 32'(exp_ovr));
        check_eq({tag, "_frame_err"}, 32'(ferr_cnt), 32'(exp_ferr));
    endtask

    initial begin
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_pop   = 1'b0;
        baudrate = 16'd8;
        repeat (3) @(negedge clk);
        check_eq("rst_empty", 32'(rx_empty), 32'd1);
        check_eq("rst_overrun", 32'(rx_overrun), 32'd0);
        check_eq("rst_frame_err", 32'(rx_frame_err), 32'd0);
        reset_n = 1'b1;
        idle(5);

        // Single byte at T = 10
        send_frame(8'hA5, 1'b1);
        check_eq("single_ready", 32'(rx_empty), 32'd0);
        drain("single");
        check_flags("single");

        // Glitch of 3 clk is rejected at start verify
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        check_eq("glitch_empty", 32'(rx_empty), 32'd1);
        check_flags("glitch");

        // Framing error, long low hold, then a good frame
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check_eq("ferr_nothing_pushed", 32'(rx_empty), 32'd1);
        check_flags("ferr");
        send_frame(8'h81, 1'b1);
        idle(5);
        drain("ferr_next");
        check_flags("ferr_next");

        // 17 back-to-back frames without pops: last one overruns
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 15) check_flags("ovr_before");
        end
        idle(5);
        check_flags("ovr_after");
        drain("ovr");

        // Reset mid-frame (during D4 of 0x55) with one byte already queued
        send_frame(8'h11, 1'b1);
        idle(5);
        check_eq("pre_reset_ready", 32'(rx_empty), 32'd0);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = bits[i];
                repeat (10) @(negedge clk);
            end
            rx = bits[5];
            repeat (5) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check_eq("midrst_empty", 32'(rx_empty), 32'd1);
        check_eq("midrst_overrun", 32'(rx_overrun), 32'd0);
        check_eq("midrst_frame_err", 32'(rx_frame_err), 32'd0);
        sb_q.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(5);
        send_frame(8'hF0, 1'b1);
        idle(5);
        drain("midrst");
        check_flags("midrst");

        // Minimum period, no gap, then a very slow frame
        baudrate = 16'd2;
        idle(5);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        baudrate = 16'd1000;
        idle(5);
        send_frame(8'h5A, 1'b1);
        idle(5);
        drain("b2b");
        check_flags("b2b");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
